// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction sequencer: bit framing, address match, ACK, RX/TX.
// Optional: define I2C_CTRL_GCALL_EN to accept the general-call address.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       sda_in,
  input  logic [7:0] rx_data,
  input  logic       tx_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic [1:0] sda_mode,
  output logic       rx_write,
  output logic       tx_read,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WAIT_STOP,
    RX_BYTE,
    RX_ACK,
    TX_LOAD,
    TX_BYTE,
    TX_ACK
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       rw, rw_nx;
  logic       nack, nack_nx;
  logic       mnack, mnack_nx;
  logic       rxw_nx;
  logic       counting;
  logic       frame8, frame9;
  logic       addr_hit;
  logic       gcall;

  assign addr_hit = (rx_data[7:1] == SLAVE_ADDR);
`ifdef I2C_CTRL_GCALL_EN
  assign gcall = (rx_data[7:1] == 7'd0);
`else
  assign gcall = 1'b0;
`endif

  assign counting = (state != IDLE) && (state != TX_LOAD);
  assign frame8   = falling_edge_found && (cnt == 4'd8);
  assign frame9   = falling_edge_found && (cnt == 4'd9);

  // State, bit counter, latched flags and the rx_write pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rw       <= 1'b0;
      nack     <= 1'b0;
      mnack    <= 1'b0;
      rx_write <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rw       <= rw_nx;
      nack     <= nack_nx;
      mnack    <= mnack_nx;
      rx_write <= rxw_nx;
    end
  end

  // Next state, counter update and Mealy shift enables
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rw_nx     = rw;
    nack_nx   = nack;
    mnack_nx  = mnack;
    rxw_nx    = 1'b0;
    rx_enable = 1'b0;
    tx_enable = 1'b0;

    if (counting) begin
      if (rising_edge_found && cnt < 4'd9)
        cnt_nx = cnt + 4'd1;
      if (frame9)
        cnt_nx = 4'd0;
    end

    unique case (state)
      ADDR: begin
        rx_enable = rising_edge_found && (cnt < 4'd8);
        if (frame8) begin
          if (addr_hit) begin
            state_nx = ADDR_ACK;
            rw_nx    = rx_data[0];
            nack_nx  = rx_data[0] & tx_empty;
          end else if (gcall) begin
            state_nx = ADDR_ACK;
            rw_nx    = 1'b0;
            nack_nx  = rx_data[0];
          end else begin
            state_nx = WAIT_STOP;
          end
        end
      end
      ADDR_ACK: begin
        if (frame9) begin
          if (nack)
            state_nx = WAIT_STOP;
          else if (rw)
            state_nx = TX_LOAD;
          else
            state_nx = RX_BYTE;
        end
      end
      RX_BYTE: begin
        rx_enable = rising_edge_found && (cnt < 4'd8);
        if (frame8) begin
          rxw_nx   = 1'b1;
          state_nx = RX_ACK;
        end
      end
      RX_ACK: begin
        if (frame9)
          state_nx = RX_BYTE;
      end
      TX_LOAD: begin
        state_nx = TX_BYTE;
      end
      TX_BYTE: begin
        tx_enable = falling_edge_found &&
                    (cnt >= 4'd1) && (cnt <= 4'd7);
        if (frame8)
          state_nx = TX_ACK;
      end
      TX_ACK: begin
        if (rising_edge_found && cnt == 4'd8)
          mnack_nx = sda_in;
        if (frame9) begin
          if (!mnack && !tx_empty)
            state_nx = TX_LOAD;
          else
            state_nx = WAIT_STOP;
        end
      end
      default: ;
    endcase

    if (stop_found) begin
      state_nx  = IDLE;
      cnt_nx    = 4'd0;
      nack_nx   = 1'b0;
      rxw_nx    = 1'b0;
      rx_enable = 1'b0;
      tx_enable = 1'b0;
    end else if (start_found) begin
      state_nx  = ADDR;
      cnt_nx    = 4'd0;
      nack_nx   = 1'b0;
      rxw_nx    = 1'b0;
      rx_enable = 1'b0;
      tx_enable = 1'b0;
    end
  end

  // Moore decode of SDA mode, FIFO pop/load and busy
  always_comb begin
    sda_mode  = 2'b00;
    busy      = 1'b0;
    load_data = 1'b0;
    tx_read   = 1'b0;
    unique case (state)
      ADDR_ACK: begin
        sda_mode = nack ? 2'b10 : 2'b01;
        busy     = !nack;
      end
      RX_BYTE: busy = 1'b1;
      RX_ACK: begin
        sda_mode = 2'b01;
        busy     = 1'b1;
      end
      TX_LOAD: begin
        sda_mode  = 2'b11;
        busy      = 1'b1;
        load_data = 1'b1;
        tx_read   = 1'b1;
      end
      TX_BYTE: begin
        sda_mode = 2'b11;
        busy     = 1'b1;
      end
      TX_ACK: busy = 1'b1;
      default: ;
    endcase
  end

endmodule
